fpalu_sequencer: RTL
====================

// Module: fpalu_sequencer
// PURPOSE
//  Multi-cycle sequencer for the FPALU in the single-cycle RV32IMF datapath. When the decoder flags an
//  FP-ALU instruction it stalls PC and register-bank writes, pulses the FPALU start and waits for ready.
//  It then commits the latched result for one cycle. A cycle-count timeout releases the core with an
//  exception flag.
//  Sits between control (wCFPstart/wCFPALUControl) and the FPALU; oStall gates the PC register enable.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max WAIT cycles before abort; legal range 2..2**CNT_W-1
//  CNT_W           7   width of WAIT-cycle counter
//  OP_W            5   width of FPALU control code
// PORTS
//  iCLK           in   1      core clock
//  iRST           in   1      asynchronous, active-high reset
//  iFPReq         in   1      decoder: current instruction is FP-ALU type (level)
//  iFPOp          in   OP_W   FPALU operation code for current instruction
//  iFPReady       in   1      FPALU result ready (synchronous to iCLK)
//  iFPResult      in   32     FPALU result bus
//  oFPStart       out  1      one-cycle start pulse to FPALU
//  oFPControl     out  OP_W   latched operation code driven to FPALU
//  oStall         out  1      1 = hold PC, suppress register/FRegister writes
//  oResultValid   out  1      one-cycle commit strobe (FReg/Reg write enable)
//  oResult        out  32     latched FPALU result, stable from DONE until next capture
//  oTimeout       out  1      one-cycle abort strobe -> exception cause logic
//  oBusy          out  1      state != IDLE
//  oStallCount    out  32     total stalled cycles since reset, wraps at 2**32
// BEHAVIOUR
//  Reset (async): state=IDLE, counter=0, oResult=0, oFPControl=0, oStallCount=0; all strobes 0.
//  States: IDLE, ISSUE, WAIT, DONE, TOUT (registered, one-hot or binary).
//  IDLE : oStall = iFPReq (combinational, so the PC does not advance in the request cycle).
//         iFPReq=1 -> latch iFPOp into oFPControl, goto ISSUE; else stay.
//  ISSUE: oFPStart=1, oStall=1, counter<=0, goto WAIT. iFPReady ignored (stale ready from prior op).
//  WAIT : oStall=1, counter++ each cycle.
//         iFPReady=1 -> oResult<=iFPResult, goto DONE (ready wins if same cycle as limit).
//         else counter==TIMEOUT_CYCLES-1 -> goto TOUT.
//  DONE : oResultValid=1, oStall=0 (PC and reg write commit on this edge), goto IDLE unconditionally;
//         iFPReq still high here must NOT restart; next FP instr is seen in following IDLE cycle.
//  TOUT : oTimeout=1, oStall=0, oResultValid=0, oResult unchanged, goto IDLE.
//  Minimum latency: req seen cycle 0, ISSUE 1, WAIT 2 with ready, DONE 3 -> 3 stalled cycles.
//  Timeout path: stalled cycles = 2 + TIMEOUT_CYCLES; oTimeout in following cycle.
//  iFPReq/iFPOp changes after IDLE are ignored; the op runs to DONE or TOUT on the latched code.
//  oStallCount increments on every cycle with oStall=1 (including IDLE request cycle).
//  oFPStart never asserted outside ISSUE; back-to-back FP instrs give one start per instruction.
//  Reset asserted mid-op: immediate IDLE, no oResultValid/oTimeout, pending FPALU result discarded.
// TESTING
//  T1 iFPReq=1, iFPOp=5'h03, ready at first WAIT, result 32'h40490FDB -> oFPStart @1, oResultValid @3,
//     oResult=32'h40490FDB, oStall=1 cycles 0-2, oStallCount=3.
//  T2 ready held high from previous op during ISSUE -> ignored. Ready at WAIT cycle 5
//     -> oResultValid at cycle 7, single oFPStart.
//  T3 TIMEOUT_CYCLES=4, ready never -> oTimeout @ cycle 6, oResultValid never, oResult unchanged,
//     IDLE @7.
//  T4 two consecutive FP instrs (iFPReq high continuously across PC change) -> exactly two oFPStart
//     pulses, two oResultValid strobes, no restart in DONE.
//  T5 iRST pulsed while in WAIT -> all outputs 0 asynchronously, oStallCount=0, later ready ignored.
//  T6 iFPReq=0 for 100 cycles -> oStall, oBusy, oFPStart stay 0; oStallCount unchanged.

Source files
------------

// File: rtl/fpalu_sequencer.sv
// rtl/fpalu_sequencer.sv - multi-cycle FPALU issue/wait/commit sequencer with cycle timeout
module fpalu_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7,
  parameter int OP_W           = 5
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iFPReq,
  input  logic [OP_W-1:0] iFPOp,
  input  logic            iFPReady,
  input  logic [31:0]     iFPResult,
  output logic            oFPStart,
  output logic [OP_W-1:0] oFPControl,
  output logic            oStall,
  output logic            oResultValid,
  output logic [31:0]     oResult,
  output logic            oTimeout,
  output logic            oBusy,
  output logic [31:0]     oStallCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_TOUT
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [OP_W-1:0]  r_op;
  logic [31:0]      r_result;
  logic [31:0]      r_stall_cnt;
  logic             w_stall;
  logic             w_start;
  logic             w_valid;
  logic             w_tout;
  logic             w_latch_op;
  logic             w_capture;
  logic             w_limit;

  assign w_limit = (r_wait_cnt == LIMIT);

  // Next-state and per-state strobes; the IDLE stall follows the request combinationally
  // so the PC is held in the very cycle the FP instruction is decoded.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_start     = 1'b0;
    w_valid     = 1'b0;
    w_tout      = 1'b0;
    w_latch_op  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = iFPReq;
        if (iFPReq) begin
          w_latch_op  = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Ready is not looked at here: it may still be high from the previous operation.
        w_start     = 1'b1;
        w_stall     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (iFPReady) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_limit) begin
          w_state_nxt = S_TOUT;
        end
      end
      S_DONE: begin
        // Always return to IDLE so a request still high here cannot restart the same op.
        w_valid     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_TOUT: begin
        w_tout      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // WAIT-cycle counter: cleared on issue, advanced on every WAIT cycle.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)                    r_wait_cnt <= '0;
    else if (r_state == S_ISSUE) r_wait_cnt <= '0;
    else if (r_state == S_WAIT)  r_wait_cnt <= r_wait_cnt + 1'b1;
  end

  // Operation code is captured once in IDLE; later changes on iFPOp are ignored.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)            r_op <= '0;
    else if (w_latch_op) r_op <= iFPOp;
  end

  // Result holding register, updated only when the FPALU reports ready in WAIT.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)           r_result <= '0;
    else if (w_capture) r_result <= iFPResult;
  end

  // Free-running count of stalled cycles, wrapping naturally at 2**32.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)         r_stall_cnt <= '0;
    else if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign oFPStart     = w_start;
  assign oFPControl   = r_op;
  assign oStall       = w_stall;
  assign oResultValid = w_valid;
  assign oResult      = r_result;
  assign oTimeout     = w_tout;
  assign oBusy        = (r_state != S_IDLE);
  assign oStallCount  = r_stall_cnt;

endmodule
